// File: rtl/ram8_ctrl_if.sv
// ram8_ctrl_if: request/response handshake bundle for the 8x16 RAM controller.
// The master drives requests and response acceptance; the slave (the RAM controller) answers.
interface ram8_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic        we;
    logic [2:0]  address;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;

    modport master (
        output in_valid, we, address, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, we, address, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/ram8_ctrl.sv
// ram8_ctrl: 8 x 16-bit RAM with a one-cycle valid/ready request/response port.
// Define RAM8_CTRL_CLEAR_EN to build in the power-on clear sequencer (8 busy cycles zeroing every word).
module ram8_ctrl (
    input  logic       clk,
    input  logic       reset_n,
    ram8_ctrl_if.slave bus
);
    logic [15:0] mem_r [8];

    logic        busy_s;
    logic        clr_we_s;
    logic [2:0]  clr_addr_s;
    logic        accept_s;
    logic        mem_we_s;
    logic [2:0]  mem_addr_s;
    logic [15:0] mem_wdata_s;
    logic        out_valid_r;
    logic [15:0] out_data_r;

`ifdef RAM8_CTRL_CLEAR_EN
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    logic [0:0] state_r;
    logic [2:0] cnt_r;

    // Clear sequencer: walks cnt through every word once, then parks in IDLE until reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_CLEAR;
            cnt_r   <= 3'd0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    cnt_r <= cnt_r + 3'd1;
                    if (cnt_r == 3'd7) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_CLEAR;
                    end
                end
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= cnt_r;
                end
                default: begin
                    state_r <= ST_CLEAR;
                    cnt_r   <= 3'd0;
                end
            endcase
        end
    end

    assign busy_s     = (state_r == ST_CLEAR);
    assign clr_we_s   = busy_s;
    assign clr_addr_s = cnt_r;
`else
    assign busy_s     = 1'b0;
    assign clr_we_s   = 1'b0;
    assign clr_addr_s = 3'd0;
`endif

    assign bus.in_ready  = !busy_s && (!out_valid_r || bus.out_ready);
    assign accept_s      = bus.in_valid && bus.in_ready;
    assign bus.busy      = busy_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;

    // Write-port select: the clear sequencer owns the array while busy, otherwise accepted writes.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_addr_s  = bus.address;
        mem_wdata_s = bus.in_data;
        if (clr_we_s) begin
            mem_we_s    = 1'b1;
            mem_addr_s  = clr_addr_s;
            mem_wdata_s = 16'h0000;
        end else if (accept_s && bus.we) begin
            mem_we_s    = 1'b1;
        end else begin
            mem_we_s    = 1'b0;
        end
    end

    // Storage array: deliberately not reset, contents only change through the write port.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_addr_s] <= mem_wdata_s;
        end
    end

    // Response register: loads on acceptance (write echoes data, read returns pre-edge contents),
    // drops when the consumer takes it without a replacement, and holds while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= 16'h0000;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= bus.we ? bus.in_data : mem_r[bus.address];
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            out_data_r  <= out_data_r;
        end else begin
            out_valid_r <= out_valid_r;
            out_data_r  <= out_data_r;
        end
    end
endmodule

// File: doc/ram8_ctrl.md
RAM8_CTRL -- requirements
Module: ram8_ctrl

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-003 SHALL have port in_valid  input  1  request present.
REQ-004 SHALL have port in_ready  output  1  request can be accepted this cycle.
REQ-005 SHALL have port we  input  1  1 = write request, 0 = read request.
REQ-006 SHALL have port address  input  3  word select, 0..7.
REQ-007 SHALL have port in_data  input  16  write data.
REQ-008 SHALL have port out_valid  output  1  response present.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the response.
REQ-010 SHALL have port out_data  output  16  response data.
REQ-011 SHALL have port busy  output  1  power-on clear in progress.

Function
REQ-012 SHALL store 8 words of 16 bits each; each bit SHALL hold its value until it is written.
REQ-013 SHALL accept a request on a rising edge where in_valid & in_ready = 1.
REQ-014 SHALL drive in_ready = !busy & (!out_valid | out_ready), combinationally.
REQ-015 SHALL, for an accepted write, update mem[address] <= in_data at that edge and load out_data <= in_data (write-first echo).
REQ-016 SHALL, for an accepted read, load out_data <= mem[address] using the contents before that edge.
REQ-017 SHALL give every accepted request exactly one response, with out_valid = 1 starting at the edge of acceptance (latency 1 cycle).
REQ-018 SHALL keep out_valid and out_data stable while out_valid = 1 and out_ready = 0.
REQ-019 SHALL clear out_valid at an edge with out_ready = 1 and no acceptance.
REQ-020 SHALL, when out_ready = 1 and a new request is accepted at the same edge, replace the response with no bubble; sustained throughput SHALL be 1 request per cycle.
REQ-021 SHALL make a read accepted the cycle after a write to the same address return the newly written data.
REQ-022 SHALL ignore in_data, we and address when no request is accepted.
REQ-023 SHALL run a power-on clear FSM, when compiled in, with states CLEAR and IDLE:
  - CLEAR: write 0x0000 to mem[cnt], then cnt <= cnt+1; busy = 1.
  - CLEAR -> IDLE after the edge that writes cnt = 7; exactly 8 busy cycles.
  - IDLE: busy = 0; the FSM stays in IDLE until the next reset.
REQ-024 SHALL stay at 3-bit width for cnt and address; no out-of-range access exists.

Reset
REQ-025 SHALL, while reset_n = 0 and independent of clk, force out_valid = 0, out_data = 0x0000 and cnt = 0.
REQ-026 SHALL, while reset_n = 0, force state = CLEAR (busy = 1) if the clear FSM is compiled in, else state = IDLE (busy = 0).
REQ-027 SHALL NOT reset memory contents asynchronously; zeroing happens only through the clear FSM.
REQ-028 SHALL, on reset asserted mid-clear or mid-transaction, discard the pending response and restart the clear from cnt = 0 after release.
REQ-029 SHALL, after reset_n rises, hold in_ready = 0 while busy = 1.

Configuration
REQ-030 SHALL compile in the power-on clear FSM only when macro RAM8_CTRL_CLEAR_EN is defined.
REQ-031 SHALL, with RAM8_CTRL_CLEAR_EN defined, read all words as 0x0000 after the 8-cycle clear until they are written.
REQ-032 SHALL, without RAM8_CTRL_CLEAR_EN, tie busy to 0, make in_ready = 1 in the first cycle after reset release, and leave memory contents undefined until written.

Verification
REQ-033 SHALL cover: (RAM8_CTRL_CLEAR_EN defined) reset_n low 3 cycles, then released -> busy = 1 and in_ready = 0 for exactly 8 cycles; reads of addresses 0..7 all return 0x0000.
REQ-034 SHALL cover: write 0xBEEF to address 5 -> next-edge response out_data = 0xBEEF; read of address 5 the following cycle -> 0xBEEF; address 4 still 0x0000.
REQ-035 SHALL cover: read address 2 (holds 0x1234) with out_ready = 0 for 4 cycles -> out_valid = 1, out_data = 0x1234 stable, in_ready = 0 throughout; raise out_ready -> a new request is accepted that cycle.
REQ-036 SHALL cover: out_ready = 1, 8 consecutive writes (data = 0x1111*addr), then 8 reads -> 16 responses on 16 consecutive cycles, read data matching.
REQ-037 SHALL cover: reset_n pulsed low at clear cycle 4 -> out_valid = 0 immediately, then 8 full busy cycles after release.
REQ-038 SHALL cover: 1000 cycles of $random in_valid, we, address, in_data and out_ready, checked every cycle against a behavioural model of mem and out_*; any mismatch prints FAIL and sets the fail flag, otherwise the bench prints "passed".
